// File: rtl/device_serial_port.sv
// Cluster device-bus responder: 8N1 UART with transmit FIFO, single-entry receive
// register, free-running 32-bit cycle counter and a record of the last TX writer.
module device_serial_port #(
    parameter int NUM_CORES     = 16,
    parameter int CLKS_PER_BIT  = 16,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         device_write_en,
    input  logic                         device_read_en,
    input  logic [9:0]                   device_addr,
    input  logic [15:0]                  device_data_out,
    output logic [15:0]                  device_data_in,
    input  logic [$clog2(NUM_CORES)-1:0] device_core_id,
    output logic                         uart_tx,
    input  logic                         uart_rx
);

    localparam int CORE_W = $clog2(NUM_CORES);
    localparam int PTR_W  = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CLK_W  = $clog2(CLKS_PER_BIT);

    localparam logic [CLK_W-1:0] BIT_END   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] HALF_END  = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(TX_FIFO_DEPTH);

    localparam logic [9:0] ADDR_STATUS    = 10'h000;
    localparam logic [9:0] ADDR_TX_DATA   = 10'h001;
    localparam logic [9:0] ADDR_RX_DATA   = 10'h002;
    localparam logic [9:0] ADDR_CYCLE_LO  = 10'h003;
    localparam logic [9:0] ADDR_CYCLE_HI  = 10'h004;
    localparam logic [9:0] ADDR_LAST_CORE = 10'h005;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic wr_status;
    logic wr_tx;
    logic rd_rx;
    logic rd_lo;

    logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tx_count;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_pop;
    logic             push;

    tx_state_t        tx_state;
    logic [CLK_W-1:0] tx_clk;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;

    logic             rx_sync1;
    logic             rx_sync2;
    rx_state_t        rx_state;
    logic [CLK_W-1:0] rx_clk;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_stop_tick;
    logic             rx_good;
    logic             rx_bad;
    logic [7:0]       rx_byte;

    logic              rx_valid;
    logic              rx_overrun;
    logic              tx_dropped;
    logic              framing_err;
    logic [CORE_W-1:0] last_core;
    logic [31:0]       cycle_cnt;
    logic [15:0]       cycle_shadow;
    logic [15:0]       rd_mux;
    logic              unused_data_hi;

    assign unused_data_hi = ^device_data_out[15:8];

    assign wr_status = device_write_en && (device_addr == ADDR_STATUS);
    assign wr_tx     = device_write_en && (device_addr == ADDR_TX_DATA);
    assign rd_rx     = device_read_en  && (device_addr == ADDR_RX_DATA);
    assign rd_lo     = device_read_en  && (device_addr == ADDR_CYCLE_LO);

    assign tx_full  = (tx_count == FIFO_FULL);
    assign tx_empty = (tx_count == '0);

    // The TX state machine pops on the same conditions it uses to start a frame.
    assign tx_pop = !tx_empty &&
                    ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_clk == BIT_END)));
    assign push   = wr_tx && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= device_data_out[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_W'(1);
                2'b01:   tx_count <= tx_count - CNT_W'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_clk   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_clk <= '0;
                    if (!tx_empty) begin
                        tx_state <= TX_START;
                        tx_shift <= fifo_mem[rd_ptr];
                        uart_tx  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_clk == BIT_END) begin
                        tx_clk   <= '0;
                        tx_idx   <= '0;
                        tx_state <= TX_DATA;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        tx_clk <= tx_clk + CLK_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_clk == BIT_END) begin
                        tx_clk <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            uart_tx  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_clk <= tx_clk + CLK_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_clk == BIT_END) begin
                        tx_clk <= '0;
                        if (!tx_empty) begin
                            tx_state <= TX_START;
                            tx_shift <= fifo_mem[rd_ptr];
                            uart_tx  <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_clk <= tx_clk + CLK_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
        end
    end

    // The start bit is confirmed at half a bit, which puts every later sample at a bit centre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_clk   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_clk <= '0;
                    if (!rx_sync2) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_clk == HALF_END) begin
                        rx_clk   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_clk <= rx_clk + CLK_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_clk == BIT_END) begin
                        rx_clk   <= '0;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_clk <= rx_clk + CLK_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_clk == BIT_END) begin
                        rx_clk   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_clk <= rx_clk + CLK_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_stop_tick = (rx_state == RX_STOP) && (rx_clk == BIT_END);
    assign rx_good      = rx_stop_tick && rx_sync2;
    assign rx_bad       = rx_stop_tick && !rx_sync2;

    always_ff @(posedge clk) begin
        if (rx_good) begin
            rx_byte <= rx_shift;
        end
    end

    // A byte landing in the same cycle as an RX_DATA read replaces the one being read, so no overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_dropped  <= 1'b0;
            framing_err <= 1'b0;
            last_core   <= '0;
        end else begin
            if (rx_good) begin
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (rx_good && rx_valid && !rd_rx) begin
                rx_overrun <= 1'b1;
            end else if (rd_rx || wr_status) begin
                rx_overrun <= 1'b0;
            end
            if (rx_bad) begin
                framing_err <= 1'b1;
            end else if (wr_status) begin
                framing_err <= 1'b0;
            end
            if (wr_tx && !push) begin
                tx_dropped <= 1'b1;
            end else if (wr_status) begin
                tx_dropped <= 1'b0;
            end
            if (push) begin
                last_core <= device_core_id;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt    <= '0;
            cycle_shadow <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (rd_lo) begin
                cycle_shadow <= cycle_cnt[31:16];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (device_addr)
            ADDR_STATUS:    rd_mux = {4'b0000, 4'(tx_count), 2'b00, framing_err, tx_dropped,
                                      rx_overrun, rx_valid, tx_empty, tx_full};
            ADDR_RX_DATA:   rd_mux = {8'h00, rx_byte};
            ADDR_CYCLE_LO:  rd_mux = cycle_cnt[15:0];
            ADDR_CYCLE_HI:  rd_mux = cycle_shadow;
            ADDR_LAST_CORE: rd_mux = 16'(last_core);
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            device_data_in <= '0;
        end else if (device_read_en) begin
            device_data_in <= rd_mux;
        end
    end

endmodule

// File: tb/tb_device_serial_port.sv
// Directed bench for device_serial_port: register map, UART TX/RX framing,
// FIFO overflow, sticky flags, asynchronous reset and cycle-counter shadowing.
module tb_device_serial_port;

    localparam int CPB = 16;

    localparam logic [9:0] A_STATUS = 10'h000;
    localparam logic [9:0] A_TX     = 10'h001;
    localparam logic [9:0] A_RX     = 10'h002;
    localparam logic [9:0] A_LO     = 10'h003;
    localparam logic [9:0] A_HI     = 10'h004;
    localparam logic [9:0] A_CORE   = 10'h005;

    logic        clk = 1'b0;
    logic        reset;
    logic        device_write_en;
    logic        device_read_en;
    logic [9:0]  device_addr;
    logic [15:0] device_data_out;
    logic [15:0] device_data_in;
    logic [3:0]  device_core_id;
    logic        uart_tx;
    logic        uart_rx;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] bc;

    logic [7:0] tx_vec [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                8'h66, 8'h77, 8'h88, 8'h99, 8'hEE};

    device_serial_port #(
        .NUM_CORES(16),
        .CLKS_PER_BIT(CPB),
        .TX_FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .device_write_en(device_write_en),
        .device_read_en(device_read_en),
        .device_addr(device_addr),
        .device_data_out(device_data_out),
        .device_data_in(device_data_in),
        .device_core_id(device_core_id),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    // Reference cycle count: what the free-running counter should hold before each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) bc <= 32'd0;
        else       bc <= bc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [15:0] d, input logic [3:0] c);
        @(negedge clk);
        device_addr     = a;
        device_data_out = d;
        device_core_id  = c;
        device_write_en = 1'b1;
        @(negedge clk);
        device_write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [9:0] a, output logic [15:0] d, output logic [31:0] at);
        @(negedge clk);
        device_addr    = a;
        device_read_en = 1'b1;
        at             = bc;
        @(negedge clk);
        device_read_en = 1'b0;
        d              = device_data_in;
    endtask

    task automatic expect_read(input logic [9:0] a, input string tag, input logic [15:0] exp);
        logic [15:0] d;
        logic [31:0] at;
        bus_read(a, d, at);
        chk(tag, 32'(d), 32'(exp));
    endtask

    // Waits for a start bit, then samples every bit at its centre; w counts cycles spent waiting.
    task automatic tx_capture(output logic [7:0] b, output logic stop_bit, output int w);
        w        = 0;
        b        = '0;
        stop_bit = 1'b0;
        while (uart_tx !== 1'b0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (uart_tx !== 1'b0) begin
            chk("tx_start_timeout", 32'(uart_tx), 32'd0);
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        chk("tx_start_mid", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = uart_tx;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [15:0] rd;
        logic [31:0] at;
        logic [7:0]  b;
        logic        sb;
        int          w;
        int          lows;
        int          guard;

        reset           = 1'b1;
        device_write_en = 1'b0;
        device_read_en  = 1'b0;
        device_addr     = '0;
        device_data_out = '0;
        device_core_id  = '0;
        uart_rx         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_rdata", 32'(device_data_in), 32'd0);
        reset = 1'b0;
        expect_read(A_STATUS, "status_after_reset", 16'h0002);

        // Single frame from core 5
        bus_write(A_TX, 16'h01A5, 4'd5);
        tx_capture(b, sb, w);
        chk("tx_a5_byte", 32'(b), 32'h0000_00A5);
        chk("tx_a5_stop", 32'(sb), 32'd1);
        expect_read(A_CORE, "last_core_5", 16'h0005);
        expect_read(A_STATUS, "status_tx_done", 16'h0002);
        expect_read(A_TX, "tx_data_reads_zero", 16'h0000);
        expect_read(10'h010, "unmapped_reads_zero", 16'h0000);

        // Ten writes while idle: first pops at once, eight fill the FIFO, tenth is dropped
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    bus_write(A_TX, {8'h00, tx_vec[i]}, (i == 9) ? 4'd15 : 4'(i));
                end
                expect_read(A_STATUS, "status_full_dropped", 16'h0811);
                expect_read(A_CORE, "last_core_not_dropped", 16'h0008);
                bus_write(A_STATUS, 16'hFFFF, 4'd0);
                expect_read(A_STATUS, "status_dropped_cleared", 16'h0801);
            end
            begin
                logic [7:0] fb;
                logic       fs;
                int         fw;
                for (int k = 0; k < 9; k++) begin
                    tx_capture(fb, fs, fw);
                    chk($sformatf("tx_burst_byte%0d", k), 32'(fb), 32'(tx_vec[k]));
                    chk($sformatf("tx_burst_stop%0d", k), 32'(fs), 32'd1);
                    if (k > 0) chk($sformatf("tx_burst_gap%0d", k), 32'(fw), 32'd8);
                end
            end
        join
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx === 1'b0) lows++;
        end
        chk("tx_no_extra_frame", 32'(lows), 32'd0);
        expect_read(A_STATUS, "status_after_burst", 16'h0002);

        // Receive path
        rx_send(8'h3C, 1'b1);
        expect_read(A_STATUS, "status_rx_valid", 16'h0006);
        expect_read(A_RX, "rx_data_3c", 16'h003C);
        expect_read(A_STATUS, "status_rx_cleared", 16'h0002);
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        expect_read(A_STATUS, "status_rx_overrun", 16'h000E);
        expect_read(A_RX, "rx_data_second", 16'h0022);
        expect_read(A_STATUS, "status_overrun_cleared", 16'h0002);
        rx_send(8'h55, 1'b0);
        expect_read(A_STATUS, "status_framing", 16'h0022);
        bus_write(A_STATUS, 16'h0000, 4'd0);
        expect_read(A_STATUS, "status_framing_cleared", 16'h0002);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        expect_read(A_STATUS, "status_after_glitch", 16'h0002);
        rx_send(8'hA7, 1'b1);
        expect_read(A_RX, "rx_data_after_glitch", 16'h00A7);

        // Asynchronous reset in the middle of a frame
        bus_write(A_TX, 16'h0000, 4'd3);
        guard = 0;
        while (uart_tx !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        chk("tx_low_before_reset", 32'(uart_tx), 32'd0);
        #1 reset = 1'b1;
        #1 chk("tx_async_reset", 32'(uart_tx), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        expect_read(A_CORE, "last_core_reset", 16'h0000);
        expect_read(A_STATUS, "status_after_midreset", 16'h0002);

        // Cycle counter and its high-half shadow
        bus_read(A_LO, rd, at);
        chk("cyc_lo_early", 32'(rd), 32'(at[15:0]));
        expect_read(A_HI, "cyc_hi_early", 16'h0000);
        guard = 0;
        while (bc != 32'h0000_FFFE && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        expect_read(A_LO, "cyc_lo_before_carry", 16'hFFFF);
        expect_read(A_HI, "cyc_hi_shadow_held", 16'h0000);
        bus_read(A_LO, rd, at);
        chk("cyc_lo_after_carry", 32'(rd), 32'(at[15:0]));
        expect_read(A_HI, "cyc_hi_after_carry", 16'h0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
